// File: rtl/in1536_out256_sched_if.sv
// rtl/in1536_out256_sched_if.sv - descriptor, stream-gate and converter-config signals of the layer scheduler
interface in1536_out256_sched_if #(
    parameter int BEATS_W = 16
);
    logic [1:0]         cfg_mode;
    logic [BEATS_W-1:0] cfg_beats;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [2:0]         conv_shift_ctrl;
    logic [8:0]         conv_shift_reg;
    logic               s_tvalid;
    logic               s_tready;
    logic               conv_s_tvalid;
    logic               conv_s_tready;
    logic               conv_m_tvalid;
    logic               conv_m_tready;
    logic               busy;
    logic               layer_done;
    logic               err_mode;

    modport slave (
        input  cfg_mode, cfg_beats, cfg_valid,
        input  s_tvalid, conv_s_tready, conv_m_tvalid, conv_m_tready,
        output cfg_ready, conv_shift_ctrl, conv_shift_reg,
        output s_tready, conv_s_tvalid, busy, layer_done, err_mode
    );

    modport master (
        output cfg_mode, cfg_beats, cfg_valid,
        output s_tvalid, conv_s_tready, conv_m_tvalid, conv_m_tready,
        input  cfg_ready, conv_shift_ctrl, conv_shift_reg,
        input  s_tready, conv_s_tvalid, busy, layer_done, err_mode
    );
endinterface

// File: rtl/in1536_out256_sched.sv
// rtl/in1536_out256_sched.sv - layer scheduler and lane-config controller for the 1536->256 width converter
module in1536_out256_sched #(
    parameter int BEATS_W    = 16,
    parameter int DESC_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    in1536_out256_sched_if.slave io_sched
);
    localparam int AW = $clog2(DESC_DEPTH);
    localparam int OW = BEATS_W + 5;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    logic [1:0]         r_fifo_mode  [DESC_DEPTH];
    logic [BEATS_W-1:0] r_fifo_beats [DESC_DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [1:0]         r_cur_mode;
    logic [BEATS_W-1:0] r_cur_beats;
    logic [BEATS_W-1:0] r_in_cnt;
    logic [OW-1:0]      r_out_cnt;
    logic [2:0]         r_shift_ctrl;
    logic [8:0]         r_shift_reg;
    logic               r_layer_done;
    logic               r_err_mode;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_gate;
    logic               w_in_hs;
    logic               w_out_hs;
    logic               w_drained;
    logic [2:0]         w_ctrl;
    logic [8:0]         w_sreg;
    logic [4:0]         w_opw;
    logic [OW-1:0]      w_layer_outs;
    logic [1:0]         w_head_mode;
    logic [BEATS_W-1:0] w_head_beats;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push       = io_sched.cfg_valid && !w_full;
    assign w_drained    = (r_out_cnt == '0);
    assign w_pop        = !w_empty && ((r_state == S_IDLE) || ((r_state == S_DRAIN) && w_drained));
    assign w_head_mode  = r_fifo_mode[r_rd_ptr[AW-1:0]];
    assign w_head_beats = r_fifo_beats[r_rd_ptr[AW-1:0]];

    // The gate term uses the registered in_cnt, so the last accepted word closes it on the next cycle.
    assign w_gate   = (r_state == S_RUN) && (r_in_cnt != '0);
    assign w_in_hs  = io_sched.s_tvalid && io_sched.conv_s_tready && w_gate;
    assign w_out_hs = io_sched.conv_m_tvalid && io_sched.conv_m_tready && !w_drained
                      && ((r_state == S_RUN) || (r_state == S_DRAIN));

    always_comb begin
        w_ctrl = 3'b100;
        w_sreg = 9'd256;
        w_opw  = 5'd6;
        case (r_cur_mode)
            2'd0: begin
                w_ctrl = 3'b001;
                w_sreg = 9'd64;
                w_opw  = 5'd24;
            end
            2'd1: begin
                w_ctrl = 3'b010;
                w_sreg = 9'd128;
                w_opw  = 5'd12;
            end
            default: ;
        endcase
    end

    // Five extra bits hold beats x 24 without wrap at the largest beat count.
    assign w_layer_outs = OW'(r_cur_beats) * OW'(w_opw);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mode[r_wr_ptr[AW-1:0]]  <= io_sched.cfg_mode;
            r_fifo_beats[r_wr_ptr[AW-1:0]] <= io_sched.cfg_beats;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur_mode   <= 2'd2;
            r_cur_beats  <= '0;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_shift_ctrl <= 3'b100;
            r_shift_reg  <= 9'd256;
            r_layer_done <= 1'b0;
            r_err_mode   <= 1'b0;
        end else begin
            r_layer_done <= 1'b0;
            r_err_mode   <= 1'b0;
            if (w_out_hs) r_out_cnt <= r_out_cnt - OW'(1);
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_cur_mode  <= w_head_mode;
                        r_cur_beats <= w_head_beats;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_cur_mode == 2'd3) begin
                        r_err_mode <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_cur_beats == '0) begin
                        r_layer_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_shift_ctrl <= w_ctrl;
                        r_shift_reg  <= w_sreg;
                        r_in_cnt     <= r_cur_beats;
                        r_out_cnt    <= w_layer_outs;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_in_hs) begin
                        r_in_cnt <= r_in_cnt - BEATS_W'(1);
                        if (r_in_cnt == BEATS_W'(1)) r_state <= S_DRAIN;
                    end else if (r_in_cnt == '0) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_layer_done <= 1'b1;
                        if (!w_empty) begin
                            r_cur_mode  <= w_head_mode;
                            r_cur_beats <= w_head_beats;
                            r_state     <= S_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_sched.cfg_ready       = !w_full;
    assign io_sched.conv_shift_ctrl = r_shift_ctrl;
    assign io_sched.conv_shift_reg  = r_shift_reg;
    assign io_sched.conv_s_tvalid   = io_sched.s_tvalid && w_gate;
    assign io_sched.s_tready        = io_sched.conv_s_tready && w_gate;
    assign io_sched.busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign io_sched.layer_done      = r_layer_done;
    assign io_sched.err_mode        = r_err_mode;
endmodule

// File: tb/tb_in1536_out256_sched.sv
// tb/tb_in1536_out256_sched.sv - scoreboard bench for the layer scheduler with a behavioural converter
module tb_in1536_out256_sched;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    in1536_out256_sched_if #(.BEATS_W(BW)) sif();

    in1536_out256_sched #(.BEATS_W(BW), .DESC_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_sched (sif)
    );

    typedef struct {
        bit         is_err;
        logic [2:0] ctrl;
        logic [8:0] sreg;
        int         ins;
        int         outs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   cur_ins = 0;
    int   cur_outs = 0;
    int   last_out_cyc = 0;
    int   pend = 0;
    bit   m_bp = 0;
    bit   rand_src = 0;
    logic [2:0] last_ctrl = 3'b100;
    logic [8:0] last_sreg = 9'd256;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] mode_ctrl(input logic [1:0] m);
        case (m)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [8:0] mode_sreg(input logic [1:0] m);
        case (m)
            2'd0:    return 9'd64;
            2'd1:    return 9'd128;
            default: return 9'd256;
        endcase
    endfunction

    function automatic int mode_opw(input logic [1:0] m);
        case (m)
            2'd0:    return 24;
            2'd1:    return 12;
            default: return 6;
        endcase
    endfunction

    function automatic int ctrl_opw(input logic [2:0] c);
        case (c)
            3'b001:  return 24;
            3'b010:  return 12;
            default: return 6;
        endcase
    endfunction

    // Monitor and scoreboard: samples on the falling edge, where handshakes for the next edge are stable.
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            cur_ins  = 0;
            cur_outs = 0;
            pend     = 0;
        end else begin
            if (sif.conv_s_tvalid && sif.conv_s_tready) begin
                cur_ins++;
                pend += ctrl_opw(sif.conv_shift_ctrl);
                check_eq("gate_only_when_busy", sif.busy, 1);
            end
            if (sif.conv_m_tvalid && sif.conv_m_tready) begin
                cur_outs++;
                pend--;
                last_out_cyc = cyc;
            end
            if (sif.layer_done || sif.err_mode) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_event", {sif.layer_done, sif.err_mode}, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("event_is_err", sif.err_mode, e.is_err);
                    check_eq("event_is_done", sif.layer_done, !e.is_err);
                    check_eq("shift_ctrl", sif.conv_shift_ctrl, e.ctrl);
                    check_eq("shift_reg", sif.conv_shift_reg, e.sreg);
                    check_eq("in_handshakes", cur_ins, e.ins);
                    check_eq("out_handshakes", cur_outs, e.outs);
                    if (e.ins > 0) check_eq("done_latency", cyc - last_out_cyc, 2);
                end
                cur_ins  = 0;
                cur_outs = 0;
            end
        end
    end

    // Behavioural converter: owes ctrl-dependent output beats for every accepted word.
    initial forever begin
        @(posedge clk);
        #1;
        sif.conv_m_tvalid = (pend > 0);
        sif.conv_m_tready = m_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rand_src) sif.s_tvalid = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input logic [1:0] m, input int b);
        exp_t e;
        int   t = 0;
        sif.cfg_mode  = m;
        sif.cfg_beats = BW'(b);
        sif.cfg_valid = 1'b1;
        while (!sif.cfg_ready && t < 3000) begin
            step();
            t++;
        end
        check_eq("push_ready", sif.cfg_ready, 1);
        e.is_err = (m == 2'd3);
        e.ins    = 0;
        e.outs   = 0;
        if (m != 2'd3 && b != 0) begin
            last_ctrl = mode_ctrl(m);
            last_sreg = mode_sreg(m);
            e.ins     = b;
            e.outs    = b * mode_opw(m);
        end
        e.ctrl = last_ctrl;
        e.sreg = last_sreg;
        sb_q.push_back(e);
        step();
        sif.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || sif.busy) && t < 3000) begin
            step();
            t++;
        end
        check_eq("drained_to_idle", sb_q.size(), 0);
        repeat (2) step();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_cfg_ready", sif.cfg_ready, 1);
        check_eq("rst_shift_ctrl", sif.conv_shift_ctrl, 3'b100);
        check_eq("rst_shift_reg", sif.conv_shift_reg, 256);
        check_eq("rst_busy", sif.busy, 0);
        check_eq("rst_layer_done", sif.layer_done, 0);
        check_eq("rst_err_mode", sif.err_mode, 0);
        check_eq("rst_s_tready", sif.s_tready, 0);
        check_eq("rst_conv_s_tvalid", sif.conv_s_tvalid, 0);
    endtask

    initial begin
        int busy_seen;
        int t;
        sif.cfg_mode      = 2'd0;
        sif.cfg_beats     = '0;
        sif.cfg_valid     = 1'b0;
        sif.s_tvalid      = 1'b1;
        sif.conv_s_tready = 1'b1;
        sif.conv_m_tvalid = 1'b0;
        sif.conv_m_tready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // mode 2, two words: 12 output beats
        push_desc(2'd2, 2);
        wait_idle();

        // illegal mode is discarded, the following descriptor runs normally
        push_desc(2'd3, 5);
        push_desc(2'd2, 1);
        wait_idle();

        // back-to-back layers with output backpressure
        m_bp = 1;
        push_desc(2'd0, 1);
        push_desc(2'd1, 1);
        wait_idle();
        m_bp = 0;

        // zero-length layer
        busy_seen = 0;
        push_desc(2'd1, 0);
        repeat (6) begin
            step();
            if (sif.busy) busy_seen++;
        end
        check_eq("zero_beats_busy", busy_seen, 0);
        wait_idle();

        // fill the descriptor FIFO behind a stalled layer
        sif.conv_s_tready = 1'b0;
        push_desc(2'd1, 2);
        repeat (3) step();
        for (int i = 0; i < 4; i++) push_desc(2'd2, 1);
        repeat (2) step();
        check_eq("fifo_full_ready", sif.cfg_ready, 0);
        check_eq("stalled_busy", sif.busy, 1);
        sif.conv_s_tready = 1'b1;
        push_desc(2'd0, 1);
        check_eq("refill_full_ready", sif.cfg_ready, 0);
        push_desc(2'd1, 2);
        wait_idle();

        // largest beat count in mode 0 with a bursty source
        rand_src = 1;
        push_desc(2'd0, 15);
        wait_idle();
        rand_src = 0;
        sif.s_tvalid = 1'b1;

        // reset in the middle of a layer, with a second descriptor queued
        push_desc(2'd1, 3);
        push_desc(2'd2, 2);
        t = 0;
        while (cur_outs < 5 && t < 500) begin
            step();
            t++;
        end
        check_eq("pre_reset_busy", sif.busy, 1);
        rst_n = 1'b0;
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        last_ctrl = 3'b100;
        last_sreg = 9'd256;
        busy_seen = 0;
        repeat (10) begin
            step();
            if (sif.busy) busy_seen++;
        end
        check_eq("fifo_flushed_by_reset", busy_seen, 0);
        push_desc(2'd1, 1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/in1536_out256_sched.md
# in1536_out256_sched

Layer scheduler and configuration controller for the 1536-bit to 256-bit flexible width converter. It accepts per-layer descriptors (output lane mode and input word count) and drives the converter's `shift_ctrl`/`shift_reg`. It gates the upstream input stream so that exactly one layer's words enter the converter. It changes configuration only after the converter has emitted every output beat of the current layer. It sits between the layer-sequencing logic and the converter's slave/master AXI-Stream handshakes.

## Interface
Parameters:
- `BEATS_W`, default 16: width of the per-layer input-word count.
- `DESC_DEPTH`, default 4: depth of the descriptor FIFO (power of 2).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_mode` in 2: lane mode.
  - 0: 64-bit lanes, replicated ×4.
  - 1: 128-bit lanes, replicated ×2.
  - 2: 256-bit lanes.
  - 3: illegal.
- `cfg_beats` in `BEATS_W`: number of 1536-bit input words in the layer.
- `cfg_valid` in 1, `cfg_ready` out 1: descriptor handshake.
- `conv_shift_ctrl` out 3: one-hot lane select to the converter.
- `conv_shift_reg` out 9: shift amount to the converter.
- `s_tvalid` in 1, `s_tready` out 1: upstream stream handshake.
- `conv_s_tvalid` out 1, `conv_s_tready` in 1: converter slave handshake.
- `conv_m_tvalid` in 1, `conv_m_tready` in 1: tap of the converter master handshake, observe only.
- `busy` out 1: a layer is loaded and not yet complete.
- `layer_done` out 1: one-cycle pulse when a layer fully drains.
- `err_mode` out 1: one-cycle pulse when an illegal descriptor is discarded.

## Operation
- Mode map:
  - Mode 0 → `shift_ctrl`=3'b001, `shift_reg`=64, 24 outputs per word.
  - Mode 1 → 3'b010, 128, 12 outputs per word.
  - Mode 2 → 3'b100, 256, 6 outputs per word.
- Descriptor FIFO:
  - `cfg_ready` = FIFO not full.
  - Push on `cfg_valid & cfg_ready`.
  - A push and a pop in the same cycle are both honoured.
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - **IDLE:** if the FIFO is non-empty, pop the head and go to LOAD; otherwise stay.
  - **LOAD (1 cycle):**
    - Mode 3: pulse `err_mode`, leave the config unchanged, return to IDLE.
    - `cfg_beats`=0: pulse `layer_done`, return to IDLE, no traffic.
    - Otherwise: register `conv_shift_ctrl`/`conv_shift_reg`, set `in_cnt`=`cfg_beats` and `out_cnt`=`cfg_beats`×outputs-per-word, then go to RUN.
  - **RUN:** gate is open. `in_cnt` decrements on each `conv_s_tvalid & conv_s_tready`. When `in_cnt` reaches 0, go to DRAIN.
  - **DRAIN:** gate is closed. When `out_cnt`=0, pulse `layer_done`. Then go to LOAD directly if the FIFO is non-empty (pop in the same cycle); otherwise go to IDLE.
- `out_cnt`:
  - Width is `BEATS_W`+5.
  - Decrements on each `conv_m_tvalid & conv_m_tready` in RUN and DRAIN.
  - Never decrements below 0. A beat observed while `out_cnt`=0 is ignored and not counted.
- Gate:
  - gate = (state==RUN) & (`in_cnt`≠0).
  - `conv_s_tvalid` = `s_tvalid` & gate.
  - `s_tready` = `conv_s_tready` & gate.
  - Both are combinational from registers and inputs only.
- `conv_shift_ctrl`/`conv_shift_reg` change only in LOAD. They are therefore constant whenever the converter holds data.
- `busy` = state ∈ {RUN, DRAIN}.

## Timing
- Reset values:
  - State IDLE, FIFO empty, `cfg_ready`=1.
  - `conv_shift_ctrl`=3'b100, `conv_shift_reg`=256.
  - `in_cnt`=`out_cnt`=0.
  - `busy`=0, `layer_done`=0, `err_mode`=0.
  - `s_tready`=0, `conv_s_tvalid`=0.
- Reset mid-layer: everything returns to the reset values on the next edge. FIFO contents are lost.
- Latency:
  - A descriptor pushed into an empty FIFO while in IDLE: IDLE pops on edge N+1, LOAD on N+2, gate open from N+2.
  - Last output beat handshake on edge M: `out_cnt`=0 after M. `layer_done` is high in the cycle after M+1, and the next LOAD starts the cycle after that.
- The last input handshake closes the gate on the following cycle. No extra word is accepted, because `in_cnt` is registered and the gate term uses it.
- Input and output handshakes may occur in the same cycle. Both counters update independently.
- `cfg_beats` max (2^`BEATS_W`−1) in mode 0 must not overflow `out_cnt`.

## Test plan
- Reset, then push {mode 2, beats 2}; drive `s_tvalid`=1 and `conv_s_tready`=1 -> exactly 2 input handshakes; `conv_shift_ctrl`=3'b100, `conv_shift_reg`=256; `layer_done` 1 cycle after the 12th output handshake.
- Push {mode 0, 1}, then {mode 1, 1} back-to-back -> config switches to 3'b010/128 only after 24 output beats; no input accepted while in DRAIN.
- Push {mode 3, 5} -> `err_mode` pulses once; config stays 3'b100/256; no input handshake; the next descriptor runs normally.
- Push {mode 1, 0} -> `layer_done` pulses with no traffic and `busy` stays 0.
- Fill the FIFO with 4 descriptors while stalled -> `cfg_ready`=0 until the first pop; simultaneous push and pop keeps the count at 4.
- Assert `rst_n`=0 mid-RUN with `out_cnt`=7 -> all outputs at reset values next cycle; `s_tready`=0.
